// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and default timing constants for the request conditioner
package traffic_pkg;

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_MAIN = 2'd1,
    E_SIDE = 2'd2
  } em_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_PRESENCE_CYCLES = 8;
  localparam int DEF_EM_HOLD_CYCLES  = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - 2-flop synchronizer followed by a consecutive-sample debouncer
module input_debouncer
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [W-1:0] CNT_MAX = W'(DEBOUNCE_CYCLES);

  logic         sync1;
  logic         sync2;
  logic [W-1:0] cnt;

  // The level flips on the sample after the count of differing samples is full;
  // any agreeing sample restarts qualification.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_request_conditioner.sv
// rtl/traffic_request_conditioner.sv - conditions raw field inputs into clean controller requests
module traffic_request_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PRESENCE_CYCLES = DEF_PRESENCE_CYCLES,
  parameter int EM_HOLD_CYCLES  = DEF_EM_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic ped_btn_raw,
  input  logic side_loop_raw,
  input  logic em_main_raw,
  input  logic em_side_raw,
  input  logic ped_ack,
  output logic ped,
  output logic SideVehicles,
  output logic em,
  output logic es,
  output logic em_conflict
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, PRESENCE_CYCLES, EM_HOLD_CYCLES) + 1);
  localparam logic [CNT_W-1:0] PRES_MAX = CNT_W'(PRESENCE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(EM_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic db_ped;
  logic db_loop;
  logic db_main;
  logic db_side;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ped (
    .clk(clk), .rst(rst), .raw(ped_btn_raw), .db(db_ped)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_loop (
    .clk(clk), .rst(rst), .raw(side_loop_raw), .db(db_loop)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_main (
    .clk(clk), .rst(rst), .raw(em_main_raw), .db(db_main)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_side (
    .clk(clk), .rst(rst), .raw(em_side_raw), .db(db_side)
  );

  logic db_ped_d;
  logic db_main_d;
  logic db_side_d;
  logic ped_rise;
  logic main_rise;
  logic side_rise;

  assign ped_rise  = db_ped & ~db_ped_d;
  assign main_rise = db_main & ~db_main_d;
  assign side_rise = db_side & ~db_side_d;

  // Pedestrian latch: a fresh press beats a same-cycle acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_ped_d <= 1'b0;
      ped      <= 1'b0;
    end else begin
      db_ped_d <= db_ped;
      if (ped_rise) begin
        ped <= 1'b1;
      end else if (ped_ack) begin
        ped <= 1'b0;
      end
    end
  end

  logic [CNT_W-1:0] pres_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pres_cnt     <= '0;
      SideVehicles <= 1'b0;
    end else if (!db_loop) begin
      pres_cnt     <= '0;
      SideVehicles <= 1'b0;
    end else if (pres_cnt != PRES_MAX) begin
      pres_cnt     <= pres_cnt + 1'b1;
      SideVehicles <= (pres_cnt == PRES_MAX - 1'b1);
    end else begin
      SideVehicles <= 1'b1;
    end
  end

  em_state_t        state;
  em_state_t        state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  logic             conflict_nxt;

  // hold_cnt is the number of cycles the current grant has been held, saturating.
  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold_cnt;
    conflict_nxt = 1'b0;
    case (state)
      E_IDLE: begin
        conflict_nxt = db_main & db_side;
        hold_nxt     = ONE;
        if (db_main) begin
          state_nxt = E_MAIN;
        end else if (db_side) begin
          state_nxt = E_SIDE;
        end
      end
      E_MAIN: begin
        conflict_nxt = side_rise;
        if (hold_cnt == HOLD_MAX && !db_main) begin
          state_nxt = E_IDLE;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      E_SIDE: begin
        conflict_nxt = main_rise;
        if (hold_cnt == HOLD_MAX && !db_side) begin
          state_nxt = E_IDLE;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = E_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= E_IDLE;
      hold_cnt    <= '0;
      db_main_d   <= 1'b0;
      db_side_d   <= 1'b0;
      em          <= 1'b0;
      es          <= 1'b0;
      em_conflict <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      db_main_d   <= db_main;
      db_side_d   <= db_side;
      em          <= (state_nxt == E_MAIN);
      es          <= (state_nxt == E_SIDE);
      em_conflict <= conflict_nxt;
    end
  end

endmodule
